axi_fill_engine: RTL and testbench
==================================

# axi_fill_engine

Parametrised AXI4 write master that fills a runtime-selected memory region with a generated data pattern, one INCR burst per block. It is the general-purpose successor to the fixed 64 KB fill block. It adds runtime base and length, three pattern modes, a bounded number of outstanding bursts, write-response checking, and busy/done/error status. It sits on an AXI4 interconnect master port and is driven by a test sequencer or control register block.

## Interface
- DW, 512: AXI data width in bits; multiple of 32, at least 32.
- AW, 32: AXI address width.
- BURST_BEATS, 64: beats per burst; 1..256; BURST_BEATS*DW/8 must be at most 4096.
- MAX_OUTSTANDING, 4: maximum bursts with AW accepted but B not yet received; at least 1.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; accepted only while busy=0.
- cfg_base_addr  in  AW  fill start address; low log2(BURST_BYTES) bits are ignored and treated as 0.
- cfg_blocks  in  16  number of bursts to write; 0 is legal.
- cfg_first_data  in  32  pattern seed.
- cfg_mode  in  2  0=incrementing, 1=constant, 2=address-as-data, 3=reserved (behaves as 0).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the fill is complete.
- error  out  1  sticky; set on any BRESP != 0; cleared on start accept.
- err_count  out  16  count of bad BRESPs; saturates at 0xFFFF; cleared on start accept.
- M_AXI_AW*  out  standard  AWADDR, AWVALID, AWLEN=BURST_BEATS-1, AWSIZE=log2(DW/8), AWBURST=1, AWID/AWLOCK/AWCACHE/AWQOS/AWPROT=0; AWREADY in.
- M_AXI_W*  out  standard  WDATA DW, WSTRB DW/8 (all ones), WVALID, WLAST; WREADY in.
- M_AXI_B*  BRESP in 2, BVALID in, BREADY out.
- M_AXI_AR*/R*  standard  read channel tied off: ARVALID=0, RREADY=0, all other outputs 0.

## Operation
- Start handling: on start accept, latch every cfg_* input into internal registers. Later changes to cfg_* have no effect until the next start.
- start while busy=1 is ignored; error and err_count are untouched.
- AW engine: states IDLE and ISSUE.
  - ISSUE drives AWADDR = base + n*BURST_BYTES for n = 0..cfg_blocks-1. Addition is modulo 2^AW (wraps silently).
  - AWVALID is asserted only while (aw_issued - b_received) < MAX_OUTSTANDING.
  - Once AWVALID is asserted, AWVALID and AWADDR hold until AWREADY.
  - Return to IDLE after the last AW handshake.
- W engine: states IDLE and SEND, independent of the AW engine. W may lead AW.
  - Beat counter runs 0..BURST_BEATS-1.
  - WLAST = WVALID && beat==BURST_BEATS-1. It does not depend on WREADY.
  - WDATA advances only on a WVALID&WREADY handshake.
  - Stop after cfg_blocks*BURST_BEATS beats.
- Patterns, with g = global beat index from 0 (32-bit, wraps):
  - mode 0: every 32-bit lane k = cfg_first_data + g*(DW/32) + k.
  - mode 1: every lane = cfg_first_data.
  - mode 2: lane k = low 32 bits of that lane's byte address.
- B channel: BREADY=1 at all times outside reset. Each BVALID increments b_received.
  - BRESP != 0 sets error and increments err_count.
- Completion: when the AW engine and W engine are idle and b_received == cfg_blocks, pulse done for one cycle and drop busy in the same cycle.

## Timing
- Reset values: AWVALID=0, WVALID=0, WLAST=0, BREADY=0, busy=0, done=0, error=0, err_count=0, AWADDR=0, WDATA=0.
- Start accepted at cycle T: busy=1, AWVALID=1, WVALID=1 at T+1, first WDATA valid at T+1.
- With ready held high on AW, W and B, throughput is one W beat per cycle with no bubbles across burst boundaries.
- cfg_blocks=0: done pulses at T+1 and busy stays 0; no AXI traffic.
- Reset asserted mid-fill: at the next edge all valids, busy and counters return to reset values; no done pulse. Any partial burst is abandoned; the environment must reset too.
- A B response arriving in the same cycle as an AW handshake updates both counters correctly (net outstanding unchanged).
- The earliest done is one cycle after the final B handshake.

## Test plan
- DW=512, BURST_BEATS=64, base=0, blocks=16, mode 0, seed=0xC0000000, all readies 1 -> 1024 beats; lane0 of beat 0 = 0xC0000000, lane0 of beat 1 = 0xC0000010; AWADDR 0x0000..0xF000 in 0x1000 steps; done once; error=0.
- BVALID withheld, MAX_OUTSTANDING=4, blocks=8 -> exactly 4 AW handshakes, then AWVALID=0 until a B is returned.
- Random AWREADY/WREADY stalls at 50% -> AWADDR, WDATA and WLAST stable while stalled; WLAST on beats 63, 127, ...; every burst has exactly 64 beats.
- mode 2, base=0x0001_0000 with misaligned low bits 0x123 -> first AWADDR = 0x0001_0000; lane k of beat 0 = 0x00010000+4k.
- BRESP=2 on bursts 3 and 5 -> error=1, err_count=2 at done; a new start clears both.
- Reset mid-fill at beat 100; start while busy; blocks=0 -> valids drop next edge; start while busy ignored; blocks=0 gives done at T+1 with no traffic.

Source files
------------

// File: rtl/axi_fill_engine.sv
// axi_fill_engine: AXI4 write master that fills a memory region with a generated
// pattern, one INCR burst of BURST_BEATS beats per block.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               single-cycle request, accepted only while busy=0
//   cfg_base_addr       fill start address (aligned down to burst size)
//   cfg_blocks          number of bursts (0 legal)
//   cfg_first_data      pattern seed
//   cfg_mode            0=incrementing, 1=constant, 2=address-as-data, 3=as 0
//   busy/done/error     status; error and err_count sticky until next start
//   err_count           saturating count of non-OKAY BRESPs
//   M_AXI_AW*/W*/B*     AXI4 write channels
//   M_AXI_AR*/R*        read channels, tied off
module axi_fill_engine #(
  parameter int DW              = 512,
  parameter int AW              = 32,
  parameter int BURST_BEATS     = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   cfg_base_addr,
  input  logic [15:0]     cfg_blocks,
  input  logic [31:0]     cfg_first_data,
  input  logic [1:0]      cfg_mode,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [15:0]     err_count,
  output logic [3:0]      M_AXI_AWID,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWLOCK,
  output logic [3:0]      M_AXI_AWCACHE,
  output logic [2:0]      M_AXI_AWPROT,
  output logic [3:0]      M_AXI_AWQOS,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [3:0]      M_AXI_ARID,
  output logic [AW-1:0]   M_AXI_ARADDR,
  output logic [7:0]      M_AXI_ARLEN,
  output logic [2:0]      M_AXI_ARSIZE,
  output logic [1:0]      M_AXI_ARBURST,
  output logic            M_AXI_ARLOCK,
  output logic [3:0]      M_AXI_ARCACHE,
  output logic [2:0]      M_AXI_ARPROT,
  output logic [3:0]      M_AXI_ARQOS,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RLAST,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY
);

  localparam int BEAT_BYTES  = DW / 8;
  localparam int BURST_BYTES = BURST_BEATS * BEAT_BYTES;
  localparam int LANES       = DW / 32;
  localparam int BW          = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  typedef enum logic {AW_IDLE, AW_ISSUE} aw_state_t;
  typedef enum logic {W_IDLE, W_SEND} w_state_t;

  aw_state_t r_aw_state, w_aw_state_nx;
  w_state_t  r_w_state, w_w_state_nx;

  logic            r_awvalid, w_awvalid_nx;
  logic            r_wvalid, w_wvalid_nx;
  logic            r_bready, r_busy, r_done, r_error;
  logic [15:0]     r_err_cnt;
  logic [AW-1:0]   r_awaddr, r_base;
  logic [DW-1:0]   r_wdata;
  logic [BW-1:0]   r_beat;
  logic [16:0]     r_wblk, r_aw_cnt, r_b_cnt;
  logic [31:0]     r_g, r_seed;
  logic [15:0]     r_blocks;
  logic [1:0]      r_mode;

  logic            w_start, w_aw_fire, w_w_fire, w_b_fire;
  logic            w_last_beat, w_w_final, w_aw_final, w_aw_room, w_complete;
  logic [16:0]     w_aw_cnt_nx, w_b_nx, w_blocks17;
  logic [AW-1:0]   w_base_aligned;
  logic            w_unused;

  // Lane k of global beat g; address mode uses the lane's own byte address.
  function automatic logic [DW-1:0] f_pattern(input logic [1:0] mode, input logic [31:0] seed,
                                              input logic [AW-1:0] base, input logic [31:0] g);
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      a = base + AW'(g) * AW'(BEAT_BYTES) + AW'(4 * k);
      case (mode)
        2'd1:    d[32*k +: 32] = seed;
        2'd2:    d[32*k +: 32] = 32'(a);
        default: d[32*k +: 32] = seed + g * 32'(LANES) + 32'(k);
      endcase
    end
    return d;
  endfunction

  assign w_start        = start && !r_busy;
  assign w_base_aligned = cfg_base_addr & ~AW'(BURST_BYTES - 1);
  assign w_blocks17     = {1'b0, r_blocks};
  assign w_aw_fire      = r_awvalid && M_AXI_AWREADY;
  assign w_w_fire       = r_wvalid && M_AXI_WREADY;
  assign w_b_fire       = M_AXI_BVALID && r_bready;
  assign w_aw_cnt_nx    = r_aw_cnt + 17'(w_aw_fire);
  assign w_b_nx         = r_b_cnt + 17'(w_b_fire);
  assign w_last_beat    = (r_beat == BW'(BURST_BEATS - 1));
  assign w_w_final      = w_w_fire && w_last_beat && (r_wblk == w_blocks17 - 17'd1);
  assign w_aw_final     = w_aw_fire && (w_aw_cnt_nx == w_blocks17);
  // Outstanding measured with this cycle's AW and B handshakes already applied.
  assign w_aw_room      = (w_aw_cnt_nx - w_b_nx) < 17'(MAX_OUTSTANDING);
  assign w_complete     = r_busy && (r_aw_state == AW_IDLE) && (r_w_state == W_IDLE) &&
                          (w_b_nx == w_blocks17);

  always_comb begin
    w_aw_state_nx = r_aw_state;
    w_awvalid_nx  = r_awvalid;
    if (r_aw_state == AW_IDLE) begin
      if (w_start && cfg_blocks != 16'd0) begin
        w_aw_state_nx = AW_ISSUE;
        w_awvalid_nx  = 1'b1;
      end
    end else begin
      if (w_aw_final) begin
        w_aw_state_nx = AW_IDLE;
        w_awvalid_nx  = 1'b0;
      end else if (w_aw_fire || !r_awvalid) begin
        w_awvalid_nx  = w_aw_room;
      end
    end
  end

  always_comb begin
    w_w_state_nx = r_w_state;
    w_wvalid_nx  = r_wvalid;
    if (r_w_state == W_IDLE) begin
      if (w_start && cfg_blocks != 16'd0) begin
        w_w_state_nx = W_SEND;
        w_wvalid_nx  = 1'b1;
      end
    end else if (w_w_final) begin
      w_w_state_nx = W_IDLE;
      w_wvalid_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_aw_state <= AW_IDLE;
      r_w_state  <= W_IDLE;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_cnt  <= '0;
      r_awaddr   <= '0;
      r_base     <= '0;
      r_wdata    <= '0;
      r_beat     <= '0;
      r_wblk     <= '0;
      r_aw_cnt   <= '0;
      r_b_cnt    <= '0;
      r_g        <= '0;
      r_seed     <= '0;
      r_blocks   <= '0;
      r_mode     <= '0;
    end else begin
      r_aw_state <= w_aw_state_nx;
      r_w_state  <= w_w_state_nx;
      r_awvalid  <= w_awvalid_nx;
      r_wvalid   <= w_wvalid_nx;
      r_bready   <= 1'b1;
      r_done     <= 1'b0;
      if (w_start) begin
        r_blocks  <= cfg_blocks;
        r_seed    <= cfg_first_data;
        r_mode    <= cfg_mode;
        r_base    <= w_base_aligned;
        r_busy    <= (cfg_blocks != 16'd0);
        r_done    <= (cfg_blocks == 16'd0);
        r_error   <= 1'b0;
        r_err_cnt <= '0;
        r_aw_cnt  <= '0;
        r_b_cnt   <= '0;
        r_beat    <= '0;
        r_wblk    <= '0;
        r_g       <= '0;
        r_awaddr  <= w_base_aligned;
        r_wdata   <= f_pattern(cfg_mode, cfg_first_data, w_base_aligned, 32'd0);
      end else begin
        if (w_aw_fire) begin
          r_aw_cnt <= w_aw_cnt_nx;
          r_awaddr <= r_awaddr + AW'(BURST_BYTES);
        end
        if (w_w_fire) begin
          r_g     <= r_g + 32'd1;
          r_wdata <= f_pattern(r_mode, r_seed, r_base, r_g + 32'd1);
          if (w_last_beat) begin
            r_beat <= '0;
            r_wblk <= r_wblk + 17'd1;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        if (w_b_fire) begin
          r_b_cnt <= w_b_nx;
          if (M_AXI_BRESP != 2'b00) begin
            r_error <= 1'b1;
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
          end
        end
        if (w_complete) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign err_count     = r_err_cnt;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
  assign M_AXI_AWSIZE  = 3'($clog2(BEAT_BYTES));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = '0;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = r_wvalid && w_last_beat;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARLEN   = '0;
  assign M_AXI_ARSIZE  = '0;
  assign M_AXI_ARBURST = '0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;

  assign w_unused = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID};

endmodule

// File: tb/tb_axi_fill_engine.sv
// Scoreboard bench for axi_fill_engine: the stimulus side pushes expected AW
// addresses and W beats computed from the pattern rules; a negedge monitor pops
// and compares on every handshake. A random-ready slave returns B responses.
module tb_axi_fill_engine;
  localparam int DW = 512, AW = 32, BB = 64, MO = 4;
  localparam int LANES = DW / 32, BYTES = DW / 8, BURST_BYTES = BB * BYTES;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [15:0] cfg_blocks = '0;
  logic [31:0] cfg_first_data = '0;
  logic [1:0] cfg_mode = '0;
  logic busy, done, error;
  logic [15:0] err_count;
  logic [3:0] awid, arid, awcache, arcache, awqos, arqos;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst;
  logic awlock, arlock, awvalid, wlast, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0] bresp = 2'b00;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;

  always #5 clk = ~clk;

  axi_fill_engine #(.DW(DW), .AW(AW), .BURST_BEATS(BB), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_blocks(cfg_blocks), .cfg_first_data(cfg_first_data), .cfg_mode(cfg_mode),
    .busy(busy), .done(done), .error(error), .err_count(err_count),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(1'b0),
    .M_AXI_RDATA('0), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(1'b0), .M_AXI_RVALID(1'b0),
    .M_AXI_RREADY(rready)
  );

  int unsigned checks = 0, failures = 0;
  longint cyc = 0, w_first = 0, w_last = 0;
  logic [31:0] exp_aw[$];
  logic [DW-1:0] exp_wd[$];
  bit exp_wl[$];
  int unsigned aw_p = 100, w_p = 100, b_p = 100;
  bit b_hold = 0, b_fire_f = 0;
  logic [63:0] bad_mask = '0;
  int unsigned aw_hs = 0, w_hs = 0, wburst_done = 0, b_sent = 0, b_done = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference pattern: lane k of global beat g, straight from the pattern rules.
  function automatic logic [DW-1:0] exp_beat(input int unsigned g, input logic [1:0] mode,
                                             input logic [31:0] seed, input logic [31:0] base);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      if (mode == 2'd1)      d[32*k +: 32] = seed;
      else if (mode == 2'd2) d[32*k +: 32] = base + g * BYTES + 32'(4 * k);
      else                   d[32*k +: 32] = seed + g * LANES + 32'(k);
    end
    return d;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave: random readies, B returned once both AW and the W burst are done.
  initial forever begin
    @(posedge clk);
    #1;
    awready = ($urandom_range(99) < aw_p);
    wready  = ($urandom_range(99) < w_p);
    if (reset) begin
      bvalid = 1'b0;
      bresp  = 2'b00;
    end else begin
      if (b_fire_f) begin
        bvalid = 1'b0;
        b_done++;
        b_fire_f = 0;
      end
      if (!bvalid && !b_hold && b_sent < ((aw_hs < wburst_done) ? aw_hs : wburst_done) &&
          $urandom_range(99) < b_p) begin
        bvalid = 1'b1;
        bresp  = bad_mask[b_sent[5:0]] ? 2'b10 : 2'b00;
        b_sent++;
      end
    end
  end

  // Monitor: handshakes are judged at negedge, ahead of the posedge that completes them.
  initial begin
    bit aw_stall, w_stall, w_stall_last;
    logic [31:0] aw_stall_addr;
    logic [DW-1:0] w_stall_data;
    aw_stall = 0;
    w_stall = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_stall = 0;
        w_stall = 0;
        b_fire_f = 0;
      end else begin
        if (aw_stall) begin
          chk("aw_stall_valid", 64'(awvalid), 64'd1);
          chk("aw_stall_addr", 64'(awaddr), 64'(aw_stall_addr));
        end
        if (w_stall) begin
          chk("w_stall_valid", 64'(wvalid), 64'd1);
          chk_wide("w_stall_data", wdata, w_stall_data);
          chk("w_stall_last", 64'(wlast), 64'(w_stall_last));
        end
        aw_stall = awvalid && !awready;
        aw_stall_addr = awaddr;
        w_stall = wvalid && !wready;
        w_stall_data = wdata;
        w_stall_last = wlast;
        if (!wvalid) chk("wlast_idle", 64'(wlast), 64'd0);
        if (awvalid && awready) begin
          aw_hs++;
          if (exp_aw.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL aw_unexpected actual=0x%0h required=none", awaddr);
          end else chk("awaddr", 64'(awaddr), 64'(exp_aw.pop_front()));
        end
        if (wvalid && wready) begin
          if (w_hs == 0) w_first = cyc;
          w_last = cyc;
          w_hs++;
          if (wlast) wburst_done++;
          if (exp_wd.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL w_unexpected actual=0x%0h required=none", wdata[31:0]);
          end else begin
            chk_wide("wdata", wdata, exp_wd.pop_front());
            chk("wlast", 64'(wlast), 64'(exp_wl.pop_front()));
          end
        end
        b_fire_f = bvalid && bready;
        if (done) begin
          done_cnt++;
          chk("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic env_clear();
    exp_aw.delete();
    exp_wd.delete();
    exp_wl.delete();
    aw_hs = 0; w_hs = 0; wburst_done = 0; b_sent = 0; b_done = 0; done_cnt = 0;
    bvalid = 1'b0;
    b_fire_f = 0;
  endtask

  task automatic issue(input logic [31:0] base, input int unsigned blocks,
                       input logic [31:0] seed, input logic [1:0] mode);
    logic [31:0] ab;
    ab = base & ~32'(BURST_BYTES - 1);
    @(posedge clk);
    #2;
    env_clear();
    for (int unsigned n = 0; n < blocks; n++) exp_aw.push_back(ab + n * BURST_BYTES);
    for (int unsigned g = 0; g < blocks * BB; g++) begin
      exp_wd.push_back(exp_beat(g, mode, seed, ab));
      exp_wl.push_back((g % BB) == BB - 1);
    end
    start = 1'b1;
    cfg_base_addr = base;
    cfg_blocks = 16'(blocks);
    cfg_first_data = seed;
    cfg_mode = mode;
    @(posedge clk);
    #2;
    start = 1'b0;
    // Scramble cfg after accept; the fill must use the latched copy.
    cfg_base_addr = $urandom;
    cfg_blocks = 16'($urandom);
    cfg_first_data = $urandom;
    cfg_mode = 2'($urandom);
    chk("t1_busy", 64'(busy), 64'(blocks != 0));
    chk("t1_awvalid", 64'(awvalid), 64'(blocks != 0));
    chk("t1_wvalid", 64'(wvalid), 64'(blocks != 0));
    chk("t1_done", 64'(done), 64'(blocks == 0));
    chk("t1_error_clr", 64'(error), 64'd0);
    chk("t1_errcnt_clr", 64'(err_count), 64'd0);
    if (blocks != 0) begin
      chk("t1_awaddr", 64'(awaddr), 64'(ab));
      chk_wide("t1_wdata", wdata, exp_beat(0, mode, seed, ab));
    end
  endtask

  task automatic wait_done(input int unsigned limit, input string name);
    int unsigned n;
    n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(name, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("aw_all_seen", 64'(exp_aw.size()), 64'd0);
    chk("w_all_seen", 64'(exp_wd.size()), 64'd0);
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_wlast", 64'(wlast), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk_wide("rst_wdata", wdata, '0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("bready_after_rst", 64'(bready), 64'd1);

    // Full-rate mode 0 fill.
    aw_p = 100; w_p = 100; b_p = 100;
    issue(32'h0, 16, 32'hC000_0000, 2'd0);
    chk("t1_lane0", 64'(wdata[31:0]), 64'hC000_0000);
    chk("awlen", 64'(awlen), 64'd63);
    chk("awsize", 64'(awsize), 64'd6);
    chk("awburst", 64'(awburst), 64'd1);
    chk("wstrb", 64'(&wstrb), 64'd1);
    wait_done(3000, "done_full");
    chk("w_no_bubbles", 64'(w_last - w_first), 64'd1023);
    chk("full_beats", 64'(w_hs), 64'd1024);
    chk("full_error", 64'(error), 64'd0);

    // Zero blocks: done at T+1, no traffic.
    issue(32'h5000, 0, 32'h1, 2'd0);
    repeat (5) @(posedge clk);
    #2;
    chk("zero_aw", 64'(aw_hs), 64'd0);
    chk("zero_w", 64'(w_hs), 64'd0);
    chk("zero_done_once", 64'(done_cnt), 64'd1);

    // B withheld: outstanding limit stops AW after MO bursts.
    b_hold = 1;
    issue(32'h2000_0000, 8, 32'h55, 2'd0);
    repeat (300) @(posedge clk);
    #2;
    chk("hold_aw_count", 64'(aw_hs), 64'(MO));
    chk("hold_awvalid", 64'(awvalid), 64'd0);
    b_hold = 0;
    wait_done(2000, "done_hold");

    // Bad responses on bursts 3 and 5, plus an ignored start mid-fill.
    bad_mask = (64'd1 << 3) | (64'd1 << 5);
    issue(32'h0, 8, 32'h7, 2'd1);
    n = 0;
    while (b_done < 4 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("err_wait_b4", 64'(b_done >= 4), 64'd1);
    start = 1'b1;
    cfg_blocks = 16'd0;
    @(posedge clk);
    #2;
    start = 1'b0;
    chk("busy_start_ignored", 64'(busy), 64'd1);
    chk("busy_start_err", 64'(error), 64'd1);
    chk("busy_start_errcnt", 64'(err_count), 64'd1);
    wait_done(2000, "done_err");
    chk("err_final", 64'(error), 64'd1);
    chk("errcnt_final", 64'(err_count), 64'd2);
    bad_mask = '0;
    issue(32'h0, 0, 32'h0, 2'd0);
    repeat (2) @(posedge clk);

    // Address-as-data with a misaligned base.
    issue(32'h0001_0123, 2, 32'h0, 2'd2);
    chk("m2_lane1", 64'(wdata[63:32]), 64'h0001_0004);
    wait_done(1000, "done_mode2");

    // Random stalls, modes and seeds.
    aw_p = 50; w_p = 50; b_p = 50;
    for (int i = 0; i < 4; i++) begin
      issue($urandom, $urandom_range(4, 1), $urandom, 2'(i));
      wait_done(5000, "done_rand");
    end

    // Reset mid-fill.
    aw_p = 100; w_p = 100; b_p = 100;
    issue(32'h0, 4, 32'hABCD_0000, 2'd0);
    n = 0;
    while (w_hs < 100 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("rst_mid_reached", 64'(w_hs >= 100), 64'd1);
    reset = 1'b1;
    env_clear();
    @(posedge clk);
    #2;
    chk("mid_awvalid", 64'(awvalid), 64'd0);
    chk("mid_wvalid", 64'(wvalid), 64'd0);
    chk("mid_wlast", 64'(wlast), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_no_done", 64'(done_cnt), 64'd0);
    chk("mid_no_aw", 64'(aw_hs), 64'd0);

    // Recovery after reset.
    issue(32'hFFFF_E000, 3, 32'h1234_5678, 2'd3);
    wait_done(2000, "done_recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
